// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate accumulate stage.
// Provides the FSM state encoding and the default datapath widths.
package mac_pkg;

    // Default widths: PW matches the wtm result bus, AW is the sum width (> PW),
    // CW is the beat-counter width.
    localparam int unsigned PW_DEFAULT = 10;
    localparam int unsigned AW_DEFAULT = 16;
    localparam int unsigned CW_DEFAULT = 8;

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

endpackage

// File: rtl/mac_accumulator_sat_add.sv
// sat_add: combinational AW-bit unsigned saturating adder.
// Ports:
//   a_i, b_i : AW-bit unsigned operands
//   sum_o    : a_i + b_i, clamped to all ones on overflow
//   sat_o    : 1 when the true sum did not fit in AW bits
module sat_add #(
    parameter int unsigned AW = 16
) (
    input  logic [AW-1:0] a_i,
    input  logic [AW-1:0] b_i,
    output logic [AW-1:0] sum_o,
    output logic          sat_o
);

    logic [AW:0] wide_sum;

    always_comb begin
        wide_sum = {1'b0, a_i} + {1'b0, b_i};
        sat_o    = wide_sum[AW];
        sum_o    = wide_sum[AW] ? '1 : wide_sum[AW-1:0];
    end

endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: accumulates bursts of wtm products into a saturating sum.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   in_valid/in_ready        : beat handshake (in_ready high only in ACC)
//   in_product, in_cout      : beat value {in_cout, in_product}, zero-extended
//   in_last                  : final beat of the burst
//   clear                    : synchronous abort, highest priority
//   out_valid/out_ready      : result handshake (out_valid high only in OUT)
//   out_sum, out_count       : saturated sum and beat count of the burst
//   out_ovf                  : sum saturated at least once in the burst
// All outputs come straight from flops, so there is no combinational path
// from in_* to out_* or from out_ready to in_ready.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int unsigned PW = PW_DEFAULT,
    parameter int unsigned AW = AW_DEFAULT,
    parameter int unsigned CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_product,
    input  logic          in_cout,
    input  logic          in_last,
    input  logic          clear,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_sum,
    output logic [CW-1:0] out_count,
    output logic          out_ovf
);

    state_t        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] out_sum_q, out_sum_d;
    logic [CW-1:0] out_count_q, out_count_d;
    logic          out_ovf_q, out_ovf_d;

    logic [AW-1:0] beat_v;
    logic [AW-1:0] add_sum;
    logic          add_sat;
    logic [CW-1:0] cnt_inc;
    logic          accept;
    logic          handoff;

    assign beat_v = AW'({in_cout, in_product});

    sat_add #(.AW(AW)) u_sat_add (
        .a_i   (acc_q),
        .b_i   (beat_v),
        .sum_o (add_sum),
        .sat_o (add_sat)
    );

    always_comb begin
        cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
        accept      = in_valid && (state_q == ST_ACC);
        handoff     = out_ready && (state_q == ST_OUT);

        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (clear) begin
            state_d     = ST_ACC;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            out_sum_d   = '0;
            out_count_d = '0;
            out_ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_ACC: begin
                    if (accept) begin
                        acc_d = add_sum;
                        cnt_d = cnt_inc;
                        ovf_d = ovf_q | add_sat;
                        if (in_last) begin
                            // Result includes the last beat itself.
                            out_sum_d   = add_sum;
                            out_count_d = cnt_inc;
                            out_ovf_d   = ovf_q | add_sat;
                            state_d     = ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    if (handoff) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = ST_ACC;
                    end
                end
                default: state_d = ST_ACC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_OUT);
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
module tb_mac_accumulator;

    localparam int unsigned PW = 10;
    localparam int unsigned AW = 16;
    localparam int unsigned CW = 8;

    typedef struct packed {
        logic [AW-1:0] sum;
        logic [CW-1:0] cnt;
        logic          ovf;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_product;
    logic          in_cout;
    logic          in_last;
    logic          clear;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum;
    logic [CW-1:0] out_count;
    logic          out_ovf;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];
    int   m_acc;
    int   m_cnt;
    logic m_ovf;

    mac_accumulator #(.PW(PW), .AW(AW), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_product (in_product),
        .in_cout    (in_cout),
        .in_last    (in_last),
        .clear      (clear),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_count  (out_count),
        .out_ovf    (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        m_acc = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    // Offer one beat starting at a negedge; returns at the negedge after acceptance.
    task automatic drive_beat(input logic [PW-1:0] p, input logic c, input logic l);
        int unsigned waited = 0;
        int s;
        in_valid   = 1'b1;
        in_product = p;
        in_cout    = c;
        in_last    = l;
        while (in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL beat_accept: in_ready got %b required 1 within 50 cycles", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        s = m_acc + int'({c, p});
        if (s > 65535) begin
            m_acc = 65535;
            m_ovf = 1'b1;
        end else begin
            m_acc = s;
        end
        if (m_cnt < 255) m_cnt++;
        if (l) begin
            sb.push_back('{sum: AW'(m_acc), cnt: CW'(m_cnt), ovf: m_ovf});
            model_clear();
        end
    endtask

    // Wait for a result, compare with the scoreboard head, then take it.
    task automatic collect(input string name);
        int unsigned waited = 0;
        exp_t e;
        while (out_valid !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid: out_valid got %b required 1 within 100 cycles", name, out_valid);
            return;
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_sb: result got with scoreboard size %0d required >0", name, sb.size());
            return;
        end
        e = sb.pop_front();
        checks++;
        if (out_sum !== e.sum) begin
            errors++;
            $display("FAIL %s_sum: got %0d required %0d", name, out_sum, e.sum);
        end
        checks++;
        if (out_count !== e.cnt) begin
            errors++;
            $display("FAIL %s_count: got %0d required %0d", name, out_count, e.cnt);
        end
        checks++;
        if (out_ovf !== e.ovf) begin
            errors++;
            $display("FAIL %s_ovf: got %b required %b", name, out_ovf, e.ovf);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: out_valid/in_ready got %b/%b required 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid   = 1'($urandom);
            in_product = PW'($urandom);
            in_cout    = 1'($urandom);
            in_last    = 1'($urandom);
            out_ready  = 1'($urandom);
            clear      = 1'($urandom);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold_valid: got %b required 0", out_valid);
            end
        end
        @(negedge clk);
        in_valid = 1'b0; in_product = '0; in_cout = 1'b0; in_last = 1'b0;
        out_ready = 1'b0; clear = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_sum !== '0 || out_count !== '0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid/sum/count/ovf got %b/%0d/%0d/%b required 0/0/0/0",
                     out_valid, out_sum, out_count, out_ovf);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        model_clear();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        drive_beat(10'd25, 1'b0, 1'b0);
        drive_beat(10'd100, 1'b0, 1'b0);
        drive_beat(10'd1023, 1'b0, 1'b1);
        collect("basic");
    endtask

    task automatic test_backpressure();
        drive_beat(10'd7, 1'b0, 1'b0);
        drive_beat(10'd8, 1'b0, 1'b1);
        in_valid = 1'b1; in_product = 10'd5; in_cout = 1'b0; in_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_sum !== 16'd15 || out_count !== 8'd2 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid/sum/count/in_ready got %b/%0d/%0d/%b required 1/15/2/0",
                         i, out_valid, out_sum, out_count, in_ready);
            end
            @(negedge clk);
        end
        collect("bp_first");
        drive_beat(10'd5, 1'b0, 1'b1);
        collect("bp_next");
    endtask

    task automatic test_saturation();
        for (int i = 1; i <= 70; i++) drive_beat(10'd1023, 1'b0, (i == 70));
        collect("sat");
    endtask

    task automatic test_carry();
        drive_beat(10'd0, 1'b1, 1'b1);
        collect("carry");
        drive_beat(10'd0, 1'b0, 1'b0);
        drive_beat(10'd0, 1'b0, 1'b1);
        collect("zero_beats");
    endtask

    task automatic test_clear();
        drive_beat(10'd50, 1'b0, 1'b0);
        drive_beat(10'd50, 1'b0, 1'b0);
        clear = 1'b1; in_valid = 1'b1; in_product = 10'd77; in_last = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        model_clear();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_acc: out_valid/in_ready got %b/%b required 0/1", out_valid, in_ready);
        end
        drive_beat(10'd9, 1'b0, 1'b1);
        collect("clear_after");
        drive_beat(10'd3, 1'b0, 1'b1);
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        void'(sb.pop_front());
        checks++;
        if (out_valid !== 1'b0 || out_sum !== '0 || out_count !== '0) begin
            errors++;
            $display("FAIL clear_out: valid/sum/count got %b/%0d/%0d required 0/0/0",
                     out_valid, out_sum, out_count);
        end
        drive_beat(10'd4, 1'b0, 1'b1);
        collect("clear_out_after");
    endtask

    task automatic test_reset_in_out();
        drive_beat(10'd3, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_out_pre: out_valid got %b required 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sum !== '0) begin
            errors++;
            $display("FAIL rst_out_async: valid/sum got %b/%0d required 0/0", out_valid, out_sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        void'(sb.pop_front());
        model_clear();
        drive_beat(10'd6, 1'b0, 1'b1);
        collect("rst_after");
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_product = '0; in_cout = 1'b0;
        in_last = 1'b0; clear = 1'b0; out_ready = 1'b0;
        model_clear();
        test_reset();
        test_basic();
        test_backpressure();
        test_saturation();
        test_carry();
        test_clear();
        test_reset_in_out();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
